lane_wb_ctrl: RTL and testbench
===============================

LANE_WB_CTRL -- requirements
Module: lane_wb_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, lane datapath width.
REQ-002 SHALL have parameter PIPE_ST, default 5, multiplier pipe stages; MUL result valid PIPE_ST-1 cycles after issue.
REQ-003 SHALL have parameter REG_W, default 5, vector register index width.
REQ-004 SHALL have parameter ELEM_W, default 3, element index width.
REQ-005 Ports, in order: clk_i in 1 clock; resetn_i in 1 reset. One clock; reset is asynchronous and active-low.
REQ-006 issue_valid_i in 1 op offered; issue_ready_o out 1 op accepted; issue_is_mul_i in 1 op is MUL/MAC class.
REQ-007 issue_vd_i in REG_W dest; issue_vs1_i, issue_vs2_i in REG_W sources; issue_elem_i in ELEM_W element; issue_mask_en_i in 1 element active.
REQ-008 alu_q_i in DATA_WIDTH ALU result bus; alu_valid_o out 1 result sampled this cycle; mul_en_o out 1 multiplier pipe enable.
REQ-009 wb_valid_o out 1; wb_we_o out 1 register-file write enable; wb_vd_o out REG_W; wb_elem_o out ELEM_W; wb_data_o out DATA_WIDTH.
REQ-010 inflight_cnt_o out $clog2(PIPE_ST+1) ops issued, not yet written back; busy_o out 1 = (inflight_cnt_o != 0).

Function
REQ-011 Issue fires in cycle t when issue_valid_i && issue_ready_o; issue_ready_o SHALL be combinational and MAY depend on issue_is_mul_i and sources.
REQ-012 ALU op fired at t: alu_q_i sampled at t; wb_valid_o=1 with that data in cycle t+1.
REQ-013 MUL op fired at t: tag {vd, elem, we} enters delay line stage 0; in cycle t+k it occupies stage k-1; alu_q_i sampled at t+PIPE_ST-1 (stage PIPE_ST-2); wb_valid_o=1 in cycle t+PIPE_ST.
REQ-014 Port-conflict stall: issue_ready_o=0 for ALU op while stage PIPE_ST-2 valid; MUL ops never blocked by this rule.
REQ-015 RAW stall: issue_ready_o=0 if issue_vs1_i or issue_vs2_i equals vd of any valid delay-line tag or the valid wb register.
REQ-016 wb_we_o = issue_mask_en_i captured at issue; masked-off ops still produce wb_valid_o=1, wb_we_o=0, wb_data_o=0.
REQ-017 alu_valid_o=1 in every cycle alu_q_i is sampled (ALU fire or MUL stage PIPE_ST-2 valid).
REQ-018 mul_en_o=1 when a MUL fires or any delay-line stage valid; otherwise 0.
REQ-019 inflight_cnt_o +1 on fire, -1 on wb_valid_o; both same cycle -> unchanged; max PIPE_ST; no underflow.
REQ-020 wb_valid_o is a single-cycle pulse per op; results SHALL retire in completion order, not issue order.

Reset
REQ-021 On resetn_i low: delay line, wb register, counter cleared; all outputs 0 except issue_ready_o, which follows REQ-014/015 with empty state.
REQ-022 Reset mid-operation discards in-flight ops; no write back after release.

Configuration
REQ-023 Macro LANE_WB_FLUSH_EN: defined -> input flush_i (1 bit) present; flush_i high forces issue_ready_o=0 and clears delay line, wb register, counter at next edge; wb_valid_o=0 the following cycle.
REQ-024 LANE_WB_FLUSH_EN undefined -> no flush_i port, no flush logic.

Structure
REQ-025 vect_pkg SHALL hold wb_tag_t {valid, vd, elem, we} and constant MUL_LAT = PIPE_ST-1 helper function.
REQ-026 Delay line SHALL be sub-module lane_wb_tag_pipe (parameterised depth, per-stage valid, combinational vd match outputs).

Verification
REQ-027 ALU op vd=3, alu_q_i=0x0000_00AA at t -> t+1: wb_valid_o=1, wb_we_o=1, wb_vd_o=3, wb_data_o=0xAA.
REQ-028 MUL vd=4 at t=0, alu_q_i=0x12 at t=4 -> t=5: wb_vd_o=4, wb_data_o=0x12; inflight_cnt_o=1 over t=1..5, 0 at t=6.
REQ-029 MUL at t=0, ALU (independent regs) offered t=4 -> issue_ready_o=0 at t=4, accepted t=5; wb at t=5 (MUL) and t=6 (ALU).
REQ-030 MUL vd=7 at t=0, ALU vs2=7 offered t=1 -> stalled until t=6, fires t=6.
REQ-031 ALU op issue_mask_en_i=0 -> wb_valid_o=1, wb_we_o=0, wb_data_o=0.
REQ-032 Three back-to-back MULs then resetn_i low at t=2 -> no wb_valid_o after release, inflight_cnt_o=0; with LANE_WB_FLUSH_EN same via flush_i.

Source files
------------

// File: rtl/vect_pkg.sv
// Shared tag type and latency helper for the vector lane write-back controller.
package vect_pkg;

  localparam int MAX_REG_W  = 8;
  localparam int MAX_ELEM_W = 8;

  // Tag fields are sized for the widest supported lane; the top casts to its own widths.
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_W-1:0]  vd;
    logic [MAX_ELEM_W-1:0] elem;
    logic                  we;
  } wb_tag_t;

  function automatic int mul_lat(input int pipe_st);
    return pipe_st - 1;
  endfunction

endpackage

// File: rtl/lane_wb_tag_pipe.sv
// Fixed-depth tag delay line that shadows the multiplier pipe and exposes
// per-cycle destination-register hits against two source indices.
module lane_wb_tag_pipe
  import vect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 clear_i,
  input  wb_tag_t              in_tag_i,
  input  logic [MAX_REG_W-1:0] src1_i,
  input  logic [MAX_REG_W-1:0] src2_i,
  output wb_tag_t              out_tag_o,
  output logic                 any_valid_o,
  output logic                 src1_hit_o,
  output logic                 src2_hit_o
);

  wb_tag_t stage_q [DEPTH];
  wb_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = clear_i ? '0 : in_tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = clear_i ? '0 : stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    src1_hit_o  = 1'b0;
    src2_hit_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_q[i].valid) begin
        any_valid_o = 1'b1;
        if (stage_q[i].vd == src1_i) src1_hit_o = 1'b1;
        if (stage_q[i].vd == src2_i) src2_hit_o = 1'b1;
      end
    end
  end

  assign out_tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lane_wb_ctrl.sv
// Vector lane write-back controller: shares one result bus between ALU and MUL ops.
// Optional feature macro: LANE_WB_FLUSH_EN adds flush_i, which drops all in-flight ops.
module lane_wb_ctrl
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_ST    = 5,
  parameter int REG_W      = 5,
  parameter int ELEM_W     = 3
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
`ifdef LANE_WB_FLUSH_EN
  input  logic                           flush_i,
`endif
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic                           issue_is_mul_i,
  input  logic [REG_W-1:0]               issue_vd_i,
  input  logic [REG_W-1:0]               issue_vs1_i,
  input  logic [REG_W-1:0]               issue_vs2_i,
  input  logic [ELEM_W-1:0]              issue_elem_i,
  input  logic                           issue_mask_en_i,
  input  logic [DATA_WIDTH-1:0]          alu_q_i,
  output logic                           alu_valid_o,
  output logic                           mul_en_o,
  output logic                           wb_valid_o,
  output logic                           wb_we_o,
  output logic [REG_W-1:0]               wb_vd_o,
  output logic [ELEM_W-1:0]              wb_elem_o,
  output logic [DATA_WIDTH-1:0]          wb_data_o,
  output logic [$clog2(PIPE_ST+1)-1:0]   inflight_cnt_o,
  output logic                           busy_o
);

  localparam int MUL_LAT = mul_lat(PIPE_ST);
  localparam int CNT_W   = $clog2(PIPE_ST+1);

  logic flush;
`ifdef LANE_WB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  wb_tag_t               wb_tag_q, wb_tag_d;
  wb_tag_t               mul_tag, last_tag;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MAX_REG_W-1:0]  src1, src2;
  logic                  pipe_busy, pipe_hit1, pipe_hit2;
  logic                  wb_hit, raw_stall, port_stall;
  logic                  fire, alu_fire, mul_fire;

  assign src1 = MAX_REG_W'(issue_vs1_i);
  assign src2 = MAX_REG_W'(issue_vs2_i);

  // A single write port: an ALU op cannot issue in the cycle a MUL result is on the bus.
  always_comb begin
    wb_hit        = wb_tag_q.valid && ((wb_tag_q.vd == src1) || (wb_tag_q.vd == src2));
    raw_stall     = pipe_hit1 || pipe_hit2 || wb_hit;
    port_stall    = !issue_is_mul_i && last_tag.valid;
    issue_ready_o = !flush && !raw_stall && !port_stall;
    fire          = issue_valid_i && issue_ready_o;
    alu_fire      = fire && !issue_is_mul_i;
    mul_fire      = fire && issue_is_mul_i;
  end

  always_comb begin
    mul_tag = '0;
    if (mul_fire) begin
      mul_tag.valid = 1'b1;
      mul_tag.vd    = MAX_REG_W'(issue_vd_i);
      mul_tag.elem  = MAX_ELEM_W'(issue_elem_i);
      mul_tag.we    = issue_mask_en_i;
    end
  end

  lane_wb_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .clear_i     (flush),
    .in_tag_i    (mul_tag),
    .src1_i      (src1),
    .src2_i      (src2),
    .out_tag_o   (last_tag),
    .any_valid_o (pipe_busy),
    .src1_hit_o  (pipe_hit1),
    .src2_hit_o  (pipe_hit2)
  );

  // Masked-off ops still retire, but with the data forced to zero.
  always_comb begin
    wb_tag_d  = '0;
    wb_data_d = '0;
    if (last_tag.valid) begin
      wb_tag_d  = last_tag;
      wb_data_d = last_tag.we ? alu_q_i : '0;
    end else if (alu_fire) begin
      wb_tag_d.valid = 1'b1;
      wb_tag_d.vd    = MAX_REG_W'(issue_vd_i);
      wb_tag_d.elem  = MAX_ELEM_W'(issue_elem_i);
      wb_tag_d.we    = issue_mask_en_i;
      wb_data_d      = issue_mask_en_i ? alu_q_i : '0;
    end
    if (flush) begin
      wb_tag_d  = '0;
      wb_data_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (fire && !wb_tag_q.valid) begin
      if (cnt_q != CNT_W'(PIPE_ST)) cnt_d = cnt_q + 1'b1;
    end else if (!fire && wb_tag_q.valid) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wb_tag_q  <= wb_tag_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign alu_valid_o    = alu_fire || last_tag.valid;
  assign mul_en_o       = mul_fire || pipe_busy;
  assign wb_valid_o     = wb_tag_q.valid;
  assign wb_we_o        = wb_tag_q.we;
  assign wb_vd_o        = REG_W'(wb_tag_q.vd);
  assign wb_elem_o      = ELEM_W'(wb_tag_q.elem);
  assign wb_data_o      = wb_data_q;
  assign inflight_cnt_o = cnt_q;
  assign busy_o         = (cnt_q != '0);

endmodule

// File: tb/tb_lane_wb_ctrl.sv
// Self-checking bench for lane_wb_ctrl: directed spec scenarios followed by random
// traffic, all checked against a timestamp-based model of in-flight operations.
module tb_lane_wb_ctrl;

  localparam int DW = 32;
  localparam int PS = 5;
  localparam int RW = 5;
  localparam int EW = 3;
  localparam int CW = $clog2(PS+1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          iv = 1'b0;
  logic          imul = 1'b0;
  logic [RW-1:0] ivd = '0;
  logic [RW-1:0] ivs1 = '0;
  logic [RW-1:0] ivs2 = '0;
  logic [EW-1:0] ielem = '0;
  logic          imask = 1'b0;
  logic [DW-1:0] aluq = '0;

  logic          issue_ready_o, alu_valid_o, mul_en_o;
  logic          wb_valid_o, wb_we_o, busy_o;
  logic [RW-1:0] wb_vd_o;
  logic [EW-1:0] wb_elem_o;
  logic [DW-1:0] wb_data_o;
  logic [CW-1:0] inflight_cnt_o;

  always #5 clk = ~clk;

  lane_wb_ctrl #(
    .DATA_WIDTH (DW),
    .PIPE_ST    (PS),
    .REG_W      (RW),
    .ELEM_W     (EW)
  ) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
`ifdef LANE_WB_FLUSH_EN
    .flush_i         (flush),
`endif
    .issue_valid_i   (iv),
    .issue_ready_o   (issue_ready_o),
    .issue_is_mul_i  (imul),
    .issue_vd_i      (ivd),
    .issue_vs1_i     (ivs1),
    .issue_vs2_i     (ivs2),
    .issue_elem_i    (ielem),
    .issue_mask_en_i (imask),
    .alu_q_i         (aluq),
    .alu_valid_o     (alu_valid_o),
    .mul_en_o        (mul_en_o),
    .wb_valid_o      (wb_valid_o),
    .wb_we_o         (wb_we_o),
    .wb_vd_o         (wb_vd_o),
    .wb_elem_o       (wb_elem_o),
    .wb_data_o       (wb_data_o),
    .inflight_cnt_o  (inflight_cnt_o),
    .busy_o          (busy_o)
  );

  // Each accepted op is remembered by the cycles in which it samples the bus and retires.
  typedef struct {
    int            issue_cyc;
    int            sample_cyc;
    int            wb_cyc;
    bit            is_mul;
    logic [RW-1:0] vd;
    logic [EW-1:0] elem;
    logic          we;
    logic [DW-1:0] data;
  } op_t;

  op_t ops[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  logic obs_ready, obs_wb_valid, obs_wb_we;
  logic [RW-1:0] obs_wb_vd;
  logic [DW-1:0] obs_wb_data;
  int obs_cnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelCycle();
    logic exp_ready, exp_alu_v, exp_mul_en, exp_fire;
    int   exp_cnt;
    int   wb_idx;
    op_t  n;
    exp_ready  = !flush;
    exp_alu_v  = 1'b0;
    exp_mul_en = 1'b0;
    exp_cnt    = 0;
    wb_idx     = -1;
    foreach (ops[i]) begin
      if (ops[i].issue_cyc < cyc && cyc <= ops[i].wb_cyc) begin
        exp_cnt++;
        if (ops[i].vd == ivs1 || ops[i].vd == ivs2) exp_ready = 1'b0;
      end
      if (ops[i].is_mul && ops[i].sample_cyc == cyc) begin
        exp_alu_v = 1'b1;
        if (!imul) exp_ready = 1'b0;
      end
      if (ops[i].is_mul && ops[i].issue_cyc < cyc && cyc < ops[i].wb_cyc) exp_mul_en = 1'b1;
      if (ops[i].wb_cyc == cyc) wb_idx = i;
    end
    exp_fire = iv && exp_ready;
    if (exp_fire && !imul) exp_alu_v = 1'b1;
    if (exp_fire && imul) exp_mul_en = 1'b1;

    obs_ready    = issue_ready_o;
    obs_wb_valid = wb_valid_o;
    obs_wb_we    = wb_we_o;
    obs_wb_vd    = wb_vd_o;
    obs_wb_data  = wb_data_o;
    obs_cnt      = int'(inflight_cnt_o);

    checkOutput("issue_ready", 64'(issue_ready_o), 64'(exp_ready));
    checkOutput("alu_valid", 64'(alu_valid_o), 64'(exp_alu_v));
    checkOutput("mul_en", 64'(mul_en_o), 64'(exp_mul_en));
    checkOutput("inflight_cnt", 64'(inflight_cnt_o), 64'(exp_cnt));
    checkOutput("busy", 64'(busy_o), 64'(exp_cnt != 0));
    checkOutput("wb_valid", 64'(wb_valid_o), 64'(wb_idx >= 0));
    if (wb_idx >= 0) begin
      checkOutput("wb_we", 64'(wb_we_o), 64'(ops[wb_idx].we));
      checkOutput("wb_vd", 64'(wb_vd_o), 64'(ops[wb_idx].vd));
      checkOutput("wb_elem", 64'(wb_elem_o), 64'(ops[wb_idx].elem));
      checkOutput("wb_data", 64'(wb_data_o), ops[wb_idx].we ? 64'(ops[wb_idx].data) : 64'd0);
    end

    foreach (ops[i]) begin
      if (ops[i].is_mul && ops[i].sample_cyc == cyc) ops[i].data = aluq;
    end
    if (exp_fire) begin
      n.issue_cyc  = cyc;
      n.is_mul     = imul;
      n.sample_cyc = imul ? cyc + PS - 1 : cyc;
      n.wb_cyc     = imul ? cyc + PS : cyc + 1;
      n.vd         = ivd;
      n.elem       = ielem;
      n.we         = imask;
      n.data       = aluq;
      ops.push_back(n);
    end
    for (int i = ops.size() - 1; i >= 0; i--) begin
      if (ops[i].wb_cyc <= cyc) ops.delete(i);
    end
    if (flush) ops.delete();
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [RW-1:0] vd,
                               input logic [RW-1:0] vs1, input logic [RW-1:0] vs2,
                               input logic [EW-1:0] el, input logic mk, input logic [DW-1:0] q);
    iv = v; imul = m; ivd = vd; ivs1 = vs1; ivs2 = vs2; ielem = el; imask = mk; aluq = q;
    @(negedge clk);
    modelCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic [DW-1:0] q);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, q);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_ready"}, 64'(issue_ready_o), 64'd1);
    checkOutput({pfx, "_alu_valid"}, 64'(alu_valid_o), 64'd0);
    checkOutput({pfx, "_mul_en"}, 64'(mul_en_o), 64'd0);
    checkOutput({pfx, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
    checkOutput({pfx, "_wb_we"}, 64'(wb_we_o), 64'd0);
    checkOutput({pfx, "_wb_vd"}, 64'(wb_vd_o), 64'd0);
    checkOutput({pfx, "_wb_data"}, 64'(wb_data_o), 64'd0);
    checkOutput({pfx, "_cnt"}, 64'(inflight_cnt_o), 64'd0);
    checkOutput({pfx, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting lane_wb_ctrl bench");
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    idle(2, '0);

    // ALU write-back one cycle after issue
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd31, 5'd31, 3'd1, 1'b1, 32'h0000_00AA);
    idle(1, '0);
    checkOutput("req027_valid", 64'(obs_wb_valid), 64'd1);
    checkOutput("req027_vd", 64'(obs_wb_vd), 64'd3);
    checkOutput("req027_data", 64'(obs_wb_data), 64'hAA);
    idle(3, '0);

    // MUL latency and in-flight count
    applyStimulus(1'b1, 1'b1, 5'd4, 5'd31, 5'd31, 3'd2, 1'b1, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      idle(1, (k == 4) ? 32'h12 : 32'hDEAD_0000);
      checkOutput("req028_cnt", 64'(obs_cnt), 64'd1);
    end
    checkOutput("req028_vd", 64'(obs_wb_vd), 64'd4);
    checkOutput("req028_data", 64'(obs_wb_data), 64'h12);
    idle(1, '0);
    checkOutput("req028_cnt_done", 64'(obs_cnt), 64'd0);
    idle(2, '0);

    // Port conflict between a retiring MUL and a new ALU op
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd31, 5'd31, 3'd0, 1'b1, 32'h0);
    idle(3, '0);
    applyStimulus(1'b1, 1'b0, 5'd2, 5'd5, 5'd6, 3'd3, 1'b1, 32'h0000_5555);
    checkOutput("req029_stall", 64'(obs_ready), 64'd0);
    applyStimulus(1'b1, 1'b0, 5'd2, 5'd5, 5'd6, 3'd3, 1'b1, 32'h0000_7777);
    checkOutput("req029_accept", 64'(obs_ready), 64'd1);
    checkOutput("req029_mul_wb", 64'(obs_wb_vd), 64'd1);
    idle(1, '0);
    checkOutput("req029_alu_wb", 64'(obs_wb_vd), 64'd2);
    checkOutput("req029_alu_data", 64'(obs_wb_data), 64'h7777);
    idle(2, '0);

    // RAW hazard on a MUL destination
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd31, 5'd31, 3'd0, 1'b1, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 5'd9, 5'd30, 5'd7, 3'd1, 1'b1, 32'h0000_0100 + 32'(k));
      checkOutput("req030_ready", 64'(obs_ready), 64'(k == 6));
    end
    idle(3, '0);

    // Masked-off ALU op
    applyStimulus(1'b1, 1'b0, 5'd6, 5'd31, 5'd31, 3'd4, 1'b0, 32'hFFFF_FFFF);
    idle(1, '0);
    checkOutput("req031_valid", 64'(obs_wb_valid), 64'd1);
    checkOutput("req031_we", 64'(obs_wb_we), 64'd0);
    checkOutput("req031_data", 64'(obs_wb_data), 64'd0);
    idle(2, '0);

    // Reset in the middle of back-to-back MULs
    applyStimulus(1'b1, 1'b1, 5'd10, 5'd31, 5'd31, 3'd0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 5'd11, 5'd31, 5'd31, 3'd1, 1'b1, 32'h0);
    iv = 1'b1; imul = 1'b1; ivd = 5'd12;
    #2;
    resetn = 1'b0;
    iv = 1'b0; imul = 1'b0; ivs1 = '0; ivs2 = '0;
    #1;
    ops.delete();
    checkResetOutputs("req032_rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc++;
    for (int k = 0; k < 8; k++) begin
      idle(1, 32'hBEEF_0000);
      checkOutput("req032_no_wb", 64'(obs_wb_valid), 64'd0);
      checkOutput("req032_cnt", 64'(obs_cnt), 64'd0);
    end

`ifdef LANE_WB_FLUSH_EN
    applyStimulus(1'b1, 1'b1, 5'd13, 5'd31, 5'd31, 3'd0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 5'd14, 5'd31, 5'd31, 3'd1, 1'b1, 32'h0);
    flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd15, 5'd31, 5'd31, 3'd2, 1'b1, 32'h0);
    checkOutput("flush_ready", 64'(obs_ready), 64'd0);
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle(1, 32'hBEEF_0001);
      checkOutput("flush_no_wb", 64'(obs_wb_valid), 64'd0);
      checkOutput("flush_cnt", 64'(obs_cnt), 64'd0);
    end
`endif

    // Random traffic over a small register set so hazards are frequent
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                    RW'($urandom_range(0, 7)), EW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 4) != 0), DW'($urandom));
    end
    idle(PS + 2, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
